dp_tap_ctrl: RTL

//  IEEE 1149.1 TAP controller for the debug port, oversampled in the iclk domain.

---
 rtl/dp_tap_pkg.sv | 51 +++++
 rtl/dp_pin_sync.sv | 40 ++++
 rtl/dp_tap_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dp_tap_pkg.sv
// dp_tap_pkg
//   Shared definitions for the debug-port TAP controller.
//   tap_state_t : the 16 TAP states with their IEEE 1149.1 encodings.
//   tap_next()  : TAP transition function, next state from current state and tms.
package dp_tap_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR = 4'h0,
      EXIT1_DR = 4'h1,
      SHIFT_DR = 4'h2,
      PAUSE_DR = 4'h3,
      SEL_IR   = 4'h4,
      UPD_DR   = 4'h5,
      CAP_DR   = 4'h6,
      SEL_DR   = 4'h7,
      EXIT2_IR = 4'h8,
      EXIT1_IR = 4'h9,
      SHIFT_IR = 4'hA,
      PAUSE_IR = 4'hB,
      RTI      = 4'hC,
      UPD_IR   = 4'hD,
      CAP_IR   = 4'hE,
      TLR      = 4'hF
   } tap_state_t;

   function automatic tap_state_t tap_next(input tap_state_t s, input logic t);
      tap_state_t n;
      n = TLR;
      case (s)
         TLR      : n = t ? TLR      : RTI;
         RTI      : n = t ? SEL_DR   : RTI;
         SEL_DR   : n = t ? SEL_IR   : CAP_DR;
         SEL_IR   : n = t ? TLR      : CAP_IR;
         CAP_DR   : n = t ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR : n = t ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR : n = t ? UPD_DR   : PAUSE_DR;
         PAUSE_DR : n = t ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR : n = t ? UPD_DR   : SHIFT_DR;
         UPD_DR   : n = t ? SEL_DR   : RTI;
         CAP_IR   : n = t ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR : n = t ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR : n = t ? UPD_IR   : PAUSE_IR;
         PAUSE_IR : n = t ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR : n = t ? UPD_IR   : SHIFT_IR;
         UPD_IR   : n = t ? SEL_DR   : RTI;
         default  : n = TLR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/dp_pin_sync.sv
// dp_pin_sync
//   Brings one asynchronous JTAG pin into the iclk domain and flags its edges.
//   Ports:
//     i_clk    internal clock
//     i_reset  synchronous active-high reset; every flop goes to RST_VAL
//     i_pin    asynchronous pin
//     o_sync   synchronized pin level (last synchronizer stage)
//     o_rise   one-cycle flag: o_sync went 0 -> 1
//     o_fall   one-cycle flag: o_sync went 1 -> 0
//   SYNC_STAGES must be at least 2.
module dp_pin_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_pin,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];
   assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/dp_tap_ctrl.sv
// dp_tap_ctrl
//   IEEE 1149.1 TAP controller oversampled in the iclk domain.
//   Ports:
//     iclk, ireset        internal clock, synchronous active-high reset
//     tck, tms, trstn     asynchronous JTAG pins (trstn active-low)
//     ir_sdo, dr_sdo      serial outputs of the IR chain and selected DR chain
//     tdo, tdo_en         JTAG data out and its output enable
//     shift_ir, shift_dr  levels, high while in SHIFT_IR / SHIFT_DR
//     clk_ir, clk_dr      one-iclk pulses: cells capture (CAP_x) or shift (SHIFT_x)
//     update_ir/_dr       one-iclk pulses on tck fall in UPD_IR / UPD_DR
//     tlr                 level, high while in TEST_LOGIC_RESET
//     tap_state           current state encoding for debug
module dp_tap_ctrl
   import dp_tap_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       iclk,
   input  logic       ireset,
   input  logic       tck,
   input  logic       tms,
   input  logic       trstn,
   input  logic       ir_sdo,
   input  logic       dr_sdo,
   output logic       tdo,
   output logic       tdo_en,
   output logic       shift_ir,
   output logic       clk_ir,
   output logic       update_ir,
   output logic       shift_dr,
   output logic       clk_dr,
   output logic       update_dr,
   output logic       tlr,
   output logic [3:0] tap_state
);

   logic w_tck_s, w_tck_rise, w_tck_fall;
   logic w_tms_s, w_unused_tms_rise, w_unused_tms_fall;
   logic w_trstn_s, w_unused_trstn_rise, w_unused_trstn_fall;
   logic w_rst;

   tap_state_t r_state, w_state_nxt;
   logic r_clk_ir, r_clk_dr, r_update_ir, r_update_dr;
   logic r_shift_ir, r_shift_dr, r_tlr;
   logic r_tdo, r_tdo_en;

   // tms goes through the same number of stages as tck so that the tms
   // value seen with a tck rise is the one present at the pin edge.
   dp_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_tck (
      .i_clk(iclk), .i_reset(ireset), .i_pin(tck),
      .o_sync(w_tck_s), .o_rise(w_tck_rise), .o_fall(w_tck_fall));

   dp_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tms (
      .i_clk(iclk), .i_reset(ireset), .i_pin(tms),
      .o_sync(w_tms_s), .o_rise(w_unused_tms_rise), .o_fall(w_unused_tms_fall));

   dp_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_trstn (
      .i_clk(iclk), .i_reset(ireset), .i_pin(trstn),
      .o_sync(w_trstn_s), .o_rise(w_unused_trstn_rise), .o_fall(w_unused_trstn_fall));

   // Either reset source forces TLR; it has priority over any tck edge
   // detected in the same cycle.
   assign w_rst = ireset | ~w_trstn_s;

   // ---------------- TAP FSM ----------------
   always_ff @(posedge iclk) begin
      if (w_rst) r_state <= TLR;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_tck_rise) w_state_nxt = tap_next(r_state, w_tms_s);
   end

   // Strobes decode the pre-transition state together with the edge flag.
   always_ff @(posedge iclk) begin
      if (w_rst) begin
         r_clk_ir    <= 1'b0;
         r_clk_dr    <= 1'b0;
         r_update_ir <= 1'b0;
         r_update_dr <= 1'b0;
      end else begin
         r_clk_ir    <= w_tck_rise & ((r_state == CAP_IR) | (r_state == SHIFT_IR));
         r_clk_dr    <= w_tck_rise & ((r_state == CAP_DR) | (r_state == SHIFT_DR));
         r_update_ir <= w_tck_fall & (r_state == UPD_IR);
         r_update_dr <= w_tck_fall & (r_state == UPD_DR);
      end
   end

   // Level decodes trail the state by one iclk; under trstn they keep
   // following the state, so shift_x drops one cycle after TLR is entered.
   always_ff @(posedge iclk) begin
      if (ireset) begin
         r_shift_ir <= 1'b0;
         r_shift_dr <= 1'b0;
         r_tlr      <= 1'b1;
      end else begin
         r_shift_ir <= (r_state == SHIFT_IR);
         r_shift_dr <= (r_state == SHIFT_DR);
         r_tlr      <= (r_state == TLR);
      end
   end

   // TDO launches on the tck falling edge and holds between falls.
   always_ff @(posedge iclk) begin
      if (w_rst) begin
         r_tdo    <= 1'b0;
         r_tdo_en <= 1'b0;
      end else if (w_tck_fall) begin
         r_tdo_en <= r_shift_ir | r_shift_dr;
         if (r_shift_ir)      r_tdo <= ir_sdo;
         else if (r_shift_dr) r_tdo <= dr_sdo;
      end
   end

   assign tdo       = r_tdo;
   assign tdo_en    = r_tdo_en;
   assign shift_ir  = r_shift_ir;
   assign shift_dr  = r_shift_dr;
   assign clk_ir    = r_clk_ir;
   assign clk_dr    = r_clk_dr;
   assign update_ir = r_update_ir;
   assign update_dr = r_update_dr;
   assign tlr       = r_tlr;
   assign tap_state = r_state;

endmodule
